// File: rtl/sal_sched_wm_pkg.sv
// Shared types and defaults for the watermark command scheduler.
package sal_sched_wm_pkg;

  localparam int unsigned BkCntDef   = 8;
  localparam int unsigned RaWDef     = 16;
  localparam int unsigned CaWDef     = 10;
  localparam int unsigned IdWDef     = 4;
  localparam int unsigned LenWDef    = 4;
  localparam int unsigned CntWDef    = 6;
  localparam int unsigned StarveWDef = 8;

  // Command class slots, one round-robin arbiter each
  localparam int unsigned ClsAct = 0;
  localparam int unsigned ClsRd  = 1;
  localparam int unsigned ClsWr  = 2;
  localparam int unsigned ClsPre = 3;
  localparam int unsigned ClsRef = 4;
  localparam int unsigned NumCls = 5;

  typedef enum logic [2:0] {
    CmdNop = 3'd0,
    CmdAct = 3'd1,
    CmdRd  = 3'd2,
    CmdWr  = 3'd3,
    CmdPre = 3'd4,
    CmdRef = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    StRd,
    StRd2Wr,
    StWr,
    StWr2Rd
  } sched_st_e;

  // Turnaround lasts max(t,1) cycles; the counter holds the cycles remaining after this one.
  function automatic logic [3:0] turn_load(input logic [3:0] t);
    return (t == 4'd0) ? 4'd0 : t - 4'd1;
  endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin arbiter: first requester at or above the pointer wins; pointer moves past it on advance.
module sal_rr_arb #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_advance,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = r_ptr + IW'(i);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= o_idx + IW'(1);
    end
  end

endmodule

// File: rtl/sal_sched_wm.sv
// DRAM command scheduler: class-priority round-robin issue with a read/write mode FSM,
// write-drain watermarks, bus turnaround and write-starvation escape.
module sal_sched_wm
  import sal_sched_wm_pkg::*;
#(
  parameter int unsigned BK_CNT   = BkCntDef,
  parameter int unsigned RA_W     = RaWDef,
  parameter int unsigned CA_W     = CaWDef,
  parameter int unsigned ID_W     = IdWDef,
  parameter int unsigned LEN_W    = LenWDef,
  parameter int unsigned CNT_W    = CntWDef,
  parameter int unsigned STARVE_W = StarveWDef
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BK_CNT-1:0]         act_req_i,
  input  logic [BK_CNT-1:0]         rd_req_i,
  input  logic [BK_CNT-1:0]         wr_req_i,
  input  logic [BK_CNT-1:0]         pre_req_i,
  input  logic [BK_CNT-1:0]         ref_req_i,
  input  logic [BK_CNT*RA_W-1:0]    ra_i,
  input  logic [BK_CNT*CA_W-1:0]    ca_i,
  input  logic [BK_CNT*ID_W-1:0]    id_i,
  input  logic [BK_CNT*LEN_W-1:0]   len_i,
  output logic [BK_CNT-1:0]         act_gnt_o,
  output logic [BK_CNT-1:0]         rd_gnt_o,
  output logic [BK_CNT-1:0]         wr_gnt_o,
  output logic [BK_CNT-1:0]         pre_gnt_o,
  output logic [BK_CNT-1:0]         ref_gnt_o,
  output logic                      cmd_valid_o,
  output logic [2:0]                cmd_type_o,
  output logic [$clog2(BK_CNT)-1:0] cmd_bk_o,
  output logic [RA_W-1:0]           cmd_ra_o,
  output logic [CA_W-1:0]           cmd_ca_o,
  output logic [ID_W-1:0]           cmd_id_o,
  output logic [LEN_W-1:0]          cmd_len_o,
  input  logic [CNT_W-1:0]          wr_pend_i,
  input  logic [CNT_W-1:0]          wm_hi_i,
  input  logic [CNT_W-1:0]          wm_lo_i,
  input  logic [STARVE_W-1:0]       starve_lim_i,
  input  logic [3:0]                t_rtw_i,
  input  logic [3:0]                t_wtr_i,
  output logic                      wr_mode_o
);

  localparam int unsigned BW = $clog2(BK_CNT);

  logic [BK_CNT-1:0] w_req  [NumCls];
  logic [BK_CNT-1:0] w_cgnt [NumCls];
  logic [BW-1:0]     w_idx  [NumCls];
  logic [NumCls-1:0] w_any;
  logic [NumCls-1:0] w_sel;
  cmd_type_e         w_type;
  logic [BW-1:0]     w_bk;

  logic [RA_W-1:0]  w_ra_arr  [BK_CNT];
  logic [CA_W-1:0]  w_ca_arr  [BK_CNT];
  logic [ID_W-1:0]  w_id_arr  [BK_CNT];
  logic [LEN_W-1:0] w_len_arr [BK_CNT];

  sched_st_e         r_state, w_state_d;
  logic [3:0]        r_tcnt, w_tcnt_d;
  logic [STARVE_W-1:0] r_starve, w_starve_d;
  logic              r_wr_seen, w_wr_seen_d, w_wr_seen_now;
  logic              w_to_wr, w_to_rd;

  logic              r_cmd_valid;
  cmd_type_e         r_cmd_type;
  logic [BW-1:0]     r_cmd_bk;
  logic [RA_W-1:0]   r_cmd_ra;
  logic [CA_W-1:0]   r_cmd_ca;
  logic [ID_W-1:0]   r_cmd_id;
  logic [LEN_W-1:0]  r_cmd_len;

  assign w_req[ClsAct] = act_req_i;
  assign w_req[ClsRd]  = rd_req_i;
  assign w_req[ClsWr]  = wr_req_i;
  assign w_req[ClsPre] = pre_req_i;
  assign w_req[ClsRef] = ref_req_i;

  for (genvar b = 0; b < BK_CNT; b++) begin : g_unpack
    assign w_ra_arr[b]  = ra_i[b*RA_W +: RA_W];
    assign w_ca_arr[b]  = ca_i[b*CA_W +: CA_W];
    assign w_id_arr[b]  = id_i[b*ID_W +: ID_W];
    assign w_len_arr[b] = len_i[b*LEN_W +: LEN_W];
  end

  // Only the selected class advances its pointer; losing classes hold.
  for (genvar c = 0; c < NumCls; c++) begin : g_arb
    sal_rr_arb #(
      .N(BK_CNT)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (w_req[c]),
      .i_advance (w_sel[c]),
      .o_gnt     (w_cgnt[c]),
      .o_idx     (w_idx[c]),
      .o_any     (w_any[c])
    );
  end

  always_comb begin
    w_sel  = '0;
    w_type = CmdNop;
    w_bk   = '0;
    if (rst_n) begin
      if (w_any[ClsRef]) begin
        w_sel[ClsRef] = 1'b1;
        w_type        = CmdRef;
        w_bk          = w_idx[ClsRef];
      end else if (r_state == StRd && w_any[ClsRd]) begin
        w_sel[ClsRd] = 1'b1;
        w_type       = CmdRd;
        w_bk         = w_idx[ClsRd];
      end else if (r_state == StWr && w_any[ClsWr]) begin
        w_sel[ClsWr] = 1'b1;
        w_type       = CmdWr;
        w_bk         = w_idx[ClsWr];
      end else if (w_any[ClsAct]) begin
        w_sel[ClsAct] = 1'b1;
        w_type        = CmdAct;
        w_bk          = w_idx[ClsAct];
      end else if (w_any[ClsPre]) begin
        w_sel[ClsPre] = 1'b1;
        w_type        = CmdPre;
        w_bk          = w_idx[ClsPre];
      end
    end
  end

  assign act_gnt_o = w_cgnt[ClsAct] & {BK_CNT{w_sel[ClsAct]}};
  assign rd_gnt_o  = w_cgnt[ClsRd]  & {BK_CNT{w_sel[ClsRd]}};
  assign wr_gnt_o  = w_cgnt[ClsWr]  & {BK_CNT{w_sel[ClsWr]}};
  assign pre_gnt_o = w_cgnt[ClsPre] & {BK_CNT{w_sel[ClsPre]}};
  assign ref_gnt_o = w_cgnt[ClsRef] & {BK_CNT{w_sel[ClsRef]}};

  assign w_to_wr = (wr_pend_i >= wm_hi_i) ||
                   (starve_lim_i != '0 && r_starve == starve_lim_i) ||
                   (rd_req_i == '0 && wr_pend_i != '0);
  assign w_to_rd = (wr_pend_i <= wm_lo_i) || (wr_req_i == '0 && rd_req_i != '0);
  // A write issued this very cycle counts, so wm_lo >= wm_hi drains exactly one write.
  assign w_wr_seen_now = r_wr_seen | w_sel[ClsWr];

  always_comb begin
    w_state_d   = r_state;
    w_tcnt_d    = r_tcnt;
    w_wr_seen_d = r_wr_seen;
    w_starve_d  = r_starve;
    unique case (r_state)
      StRd: begin
        if (w_to_wr) begin
          w_state_d = StRd2Wr;
          w_tcnt_d  = turn_load(t_rtw_i);
        end
      end
      StRd2Wr: begin
        if (r_tcnt == 4'd0) begin
          w_state_d   = StWr;
          w_wr_seen_d = 1'b0;
        end else begin
          w_tcnt_d = r_tcnt - 4'd1;
        end
      end
      StWr: begin
        w_wr_seen_d = w_wr_seen_now;
        if (w_wr_seen_now && w_to_rd) begin
          w_state_d = StWr2Rd;
          w_tcnt_d  = turn_load(t_wtr_i);
        end
      end
      StWr2Rd: begin
        if (r_tcnt == 4'd0) begin
          w_state_d = StRd;
        end else begin
          w_tcnt_d = r_tcnt - 4'd1;
        end
      end
      default: w_state_d = StRd;
    endcase
    if (wr_pend_i == '0 || (r_state == StRd2Wr && w_state_d == StWr)) begin
      w_starve_d = '0;
    end else if (r_state == StRd && r_starve != '1) begin
      w_starve_d = r_starve + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StRd;
      r_tcnt    <= '0;
      r_starve  <= '0;
      r_wr_seen <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_tcnt    <= w_tcnt_d;
      r_starve  <= w_starve_d;
      r_wr_seen <= w_wr_seen_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CmdNop;
      r_cmd_bk    <= '0;
      r_cmd_ra    <= '0;
      r_cmd_ca    <= '0;
      r_cmd_id    <= '0;
      r_cmd_len   <= '0;
    end else begin
      r_cmd_valid <= |w_sel;
      r_cmd_type  <= w_type;
      r_cmd_bk    <= w_bk;
      r_cmd_ra    <= (|w_sel) ? w_ra_arr[w_bk]  : '0;
      r_cmd_ca    <= (|w_sel) ? w_ca_arr[w_bk]  : '0;
      r_cmd_id    <= (|w_sel) ? w_id_arr[w_bk]  : '0;
      r_cmd_len   <= (|w_sel) ? w_len_arr[w_bk] : '0;
    end
  end

  assign cmd_valid_o = r_cmd_valid;
  assign cmd_type_o  = r_cmd_type;
  assign cmd_bk_o    = r_cmd_bk;
  assign cmd_ra_o    = r_cmd_ra;
  assign cmd_ca_o    = r_cmd_ca;
  assign cmd_id_o    = r_cmd_id;
  assign cmd_len_o   = r_cmd_len;
  assign wr_mode_o   = (r_state == StWr) || (r_state == StRd2Wr);

endmodule

// File: tb/tb_sal_sched_wm.sv
// Randomized bench for sal_sched_wm against a cycle-level behavioural model of the scheduler rules.
module tb_sal_sched_wm;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   act_req, rd_req, wr_req, pre_req, ref_req;
  logic [127:0] ra;
  logic [79:0]  ca;
  logic [31:0]  id, len;
  logic [7:0]   act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
  logic         cmd_valid_o;
  logic [2:0]   cmd_type_o, cmd_bk_o;
  logic [15:0]  cmd_ra_o;
  logic [9:0]   cmd_ca_o;
  logic [3:0]   cmd_id_o, cmd_len_o;
  logic [5:0]   wr_pend, wm_hi, wm_lo;
  logic [7:0]   starve_lim;
  logic [3:0]   t_rtw, t_wtr;
  logic         wr_mode_o;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 RD, 1 RD2WR, 2 WR, 3 WR2RD; dwell = turnaround cycles still to spend
  int          m_ptr [5];
  int          m_mode, m_dwell, m_starve;
  bit          m_seen;
  bit          e_valid;
  int          e_type;
  logic [36:0] e_fields;

  always #5 clk = ~clk;

  sal_sched_wm u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .act_req_i    (act_req),
    .rd_req_i     (rd_req),
    .wr_req_i     (wr_req),
    .pre_req_i    (pre_req),
    .ref_req_i    (ref_req),
    .ra_i         (ra),
    .ca_i         (ca),
    .id_i         (id),
    .len_i        (len),
    .act_gnt_o    (act_gnt_o),
    .rd_gnt_o     (rd_gnt_o),
    .wr_gnt_o     (wr_gnt_o),
    .pre_gnt_o    (pre_gnt_o),
    .ref_gnt_o    (ref_gnt_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_type_o   (cmd_type_o),
    .cmd_bk_o     (cmd_bk_o),
    .cmd_ra_o     (cmd_ra_o),
    .cmd_ca_o     (cmd_ca_o),
    .cmd_id_o     (cmd_id_o),
    .cmd_len_o    (cmd_len_o),
    .wr_pend_i    (wr_pend),
    .wm_hi_i      (wm_hi),
    .wm_lo_i      (wm_lo),
    .starve_lim_i (starve_lim),
    .t_rtw_i      (t_rtw),
    .t_wtr_i      (t_wtr),
    .wr_mode_o    (wr_mode_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  function automatic int max1(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 5; c++) m_ptr[c] = 0;
    m_mode   = 0;
    m_dwell  = 0;
    m_starve = 0;
    m_seen   = 1'b0;
    e_valid  = 1'b0;
    e_type   = 0;
    e_fields = '0;
  endtask

  // Called at a negedge with inputs set; checks, advances the model, returns at the next negedge.
  task automatic cycle();
    logic [7:0] req [5];
    logic [7:0] eg [5];
    int cls, win, old_mode;
    bit into_wr;
    for (int b = 0; b < 8; b++) begin
      ra[b*16 +: 16] = 16'($urandom);
      ca[b*10 +: 10] = 10'($urandom);
      id[b*4 +: 4]   = 4'($urandom);
      len[b*4 +: 4]  = 4'($urandom);
    end
    #1;
    chk("cmd_valid", 64'(cmd_valid_o), 64'(e_valid));
    chk("cmd_type", 64'(cmd_type_o), 64'(e_type));
    chk("cmd_fields", 64'({cmd_bk_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o}), 64'(e_fields));
    chk("wr_mode", 64'(wr_mode_o), 64'(m_mode == 1 || m_mode == 2));
    req[0] = act_req; req[1] = rd_req; req[2] = wr_req; req[3] = pre_req; req[4] = ref_req;
    for (int c = 0; c < 5; c++) eg[c] = 8'h00;
    cls = -1;
    win = 0;
    if (ref_req != 0) cls = 4;
    else if (m_mode == 0 && rd_req != 0) cls = 1;
    else if (m_mode == 2 && wr_req != 0) cls = 2;
    else if (act_req != 0) cls = 0;
    else if (pre_req != 0) cls = 3;
    if (cls >= 0) begin
      win = pick(req[cls], m_ptr[cls]);
      eg[cls][win] = 1'b1;
    end
    chk("gnt", 64'({ref_gnt_o, pre_gnt_o, wr_gnt_o, rd_gnt_o, act_gnt_o}),
        64'({eg[4], eg[3], eg[2], eg[1], eg[0]}));
    if (cls >= 0) begin
      e_valid  = 1'b1;
      e_type   = cls + 1;
      e_fields = {3'(win), ra[win*16 +: 16], ca[win*10 +: 10], id[win*4 +: 4], len[win*4 +: 4]};
      m_ptr[cls] = (win + 1) % 8;
    end else begin
      e_valid  = 1'b0;
      e_type   = 0;
      e_fields = '0;
    end
    old_mode = m_mode;
    into_wr  = 1'b0;
    case (m_mode)
      0: if (wr_pend >= wm_hi || (starve_lim != 0 && m_starve == int'(starve_lim)) ||
             (rd_req == 0 && wr_pend != 0)) begin
        m_mode  = 1;
        m_dwell = max1(int'(t_rtw));
      end
      1: begin
        m_dwell--;
        if (m_dwell == 0) begin
          m_mode  = 2;
          m_seen  = 1'b0;
          into_wr = 1'b1;
        end
      end
      2: begin
        m_seen = m_seen || (cls == 2);
        if (m_seen && (wr_pend <= wm_lo || (wr_req == 0 && rd_req != 0))) begin
          m_mode  = 3;
          m_dwell = max1(int'(t_wtr));
        end
      end
      default: begin
        m_dwell--;
        if (m_dwell == 0) m_mode = 0;
      end
    endcase
    if (wr_pend == 0 || into_wr) m_starve = 0;
    else if (old_mode == 0 && m_starve < 255) m_starve++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 64'({ref_gnt_o, pre_gnt_o, wr_gnt_o, rd_gnt_o, act_gnt_o}), 64'(0));
    chk("rst_valid", 64'(cmd_valid_o), 64'(0));
    chk("rst_type", 64'(cmd_type_o), 64'(0));
    chk("rst_mode", 64'(wr_mode_o), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] t1_exp [3];
    int n, g, nw;
    t1_exp = '{8'h01, 8'h04, 8'h01};
    rst_n = 1'b0;
    {act_req, rd_req, wr_req, pre_req, ref_req} = '0;
    ra = '0; ca = '0; id = '0; len = '0;
    wr_pend = 6'd0; wm_hi = 6'd8; wm_lo = 6'd2; starve_lim = 8'd0;
    t_rtw = 4'd3; t_wtr = 4'd2;
    model_reset();
    @(negedge clk);
    do_reset();

    // Plain read round-robin
    rd_req = 8'h05;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t1_rd_gnt", 64'(rd_gnt_o), 64'(t1_exp[k]));
      cycle();
    end

    // REF beats CAS; read pointer holds and the read follows
    rd_req = 8'h10; ref_req = 8'h10;
    #1;
    chk("t3_ref_gnt", 64'(ref_gnt_o), 64'(8'h10));
    chk("t3_rd_held", 64'(rd_gnt_o), 64'(0));
    cycle();
    ref_req = 8'h00;
    #1;
    chk("t3_rd_next", 64'(rd_gnt_o), 64'(8'h10));
    cycle();

    // Watermark drain with turnarounds
    rd_req = 8'hff; wr_req = 8'hff;
    for (int k = 0; k <= 8; k++) begin
      wr_pend = 6'(k);
      cycle();
    end
    for (int k = 0; k < 8; k++) cycle();
    wr_pend = 6'd2;
    for (int k = 0; k < 8; k++) cycle();

    // Write starvation escape
    do_reset();
    starve_lim = 8'd20; wm_hi = 6'd60; wr_pend = 6'd1; rd_req = 8'hff; wr_req = 8'h00;
    n = 0;
    while (!wr_mode_o && n < 100) begin
      cycle();
      n++;
    end
    chk("t4_switch", 64'(n), 64'(21));
    wr_req = 8'hff;
    for (int k = 0; k < 40; k++) cycle();

    // Inverted watermarks: one write per WR visit
    do_reset();
    starve_lim = 8'd0; wm_lo = 6'd10; wm_hi = 6'd5; wr_pend = 6'd6;
    t_rtw = 4'd0; t_wtr = 4'd0; rd_req = 8'h00; wr_req = 8'hff;
    g = 0; nw = 0;
    while (!wr_mode_o && g < 10) begin
      cycle();
      g++;
    end
    while (wr_mode_o && g < 30) begin
      #1;
      if (wr_gnt_o != 0) nw++;
      cycle();
      g++;
    end
    chk("t5_wr_per_visit", 64'(nw), 64'(1));

    // Reset in the middle of WR2RD
    t_wtr = 4'd3;
    g = 0;
    while (!(m_mode == 3 && m_dwell == 2) && g < 40) begin
      cycle();
      g++;
    end
    chk("t6_reach_wr2rd", 64'(m_mode == 3 && m_dwell == 2), 64'(1));
    rd_req = 8'hff;
    do_reset();
    #1;
    chk("t6_rd_gnt", 64'(rd_gnt_o), 64'(8'h01));
    cycle();

    // Randomized phases
    for (int p = 0; p < 6; p++) begin
      if (p % 2 == 0) do_reset();
      wm_hi = 6'($urandom_range(1, 40));
      wm_lo = 6'($urandom_range(0, 40));
      t_rtw = 4'($urandom);
      t_wtr = 4'($urandom);
      starve_lim = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(3, 60));
      for (int k = 0; k < 400; k++) begin
        act_req = 8'($urandom & $urandom);
        rd_req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        wr_req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        pre_req = 8'($urandom & $urandom & $urandom);
        ref_req = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        if ($urandom_range(0, 7) == 0) wr_pend = 6'($urandom_range(0, 63));
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
